// File: rtl/median_pkg.sv
// Shared constants, state encoding and comparison schedule for the
// median-of-5 stream block.
package median_pkg;

    localparam int DW = 8;   // sample width, two's complement
    localparam int NS = 5;   // samples per frame
    localparam int IW = 3;   // slot index width
    localparam int RW = 3;   // rank counter width (max rank 4)
    localparam int NP = 10;  // number of pairwise comparisons per frame
    localparam int PW = 4;   // pair counter width

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CMP  = 2'd1,
        SEL  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Fixed comparison order: every unordered pair of slots exactly once.
    localparam logic [IW-1:0] PAIR_A [0:NP-1] = '{
        3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3
    };
    localparam logic [IW-1:0] PAIR_B [0:NP-1] = '{
        3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd4
    };

    // With a strict total order, ranks are 0..4 and the median holds rank 2.
    localparam logic [RW-1:0] MEDIAN_RANK = 3'd2;

endpackage

// File: rtl/median5_pair_cmp.sv
// Single pairwise comparator: signed magnitude compare, ties broken by
// arrival index so that no two distinct slots ever compare as equal.
module median5_pair_cmp
    import median_pkg::*;
(
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [IW-1:0] ia_i,
    input  logic [IW-1:0] ib_i,
    output logic          a_gt_b_o
);

    logic val_gt;
    logic val_eq;

    assign val_gt   = $signed(a_i) > $signed(b_i);
    assign val_eq   = (a_i == b_i);
    assign a_gt_b_o = val_gt || (val_eq && (ia_i > ib_i));

endmodule

// File: rtl/median5_stream.sv
// Median-of-5 stream block: collects five signed samples, ranks them with one
// time-shared comparator over ten cycles, then presents the rank-2 sample and
// its arrival index on a registered valid/ready output.
module median5_stream
    import median_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_idx
);

    state_t        state_q;
    logic [IW-1:0] cnt_q;
    logic [PW-1:0] pair_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic [IW-1:0] out_idx_q;

    logic [DW-1:0] slot_q [NS];
    logic [RW-1:0] rank_q [NS];
    logic [RW-1:0] rank_d [NS];

    logic          accept;
    logic          load_last;
    logic [IW-1:0] pa;
    logic [IW-1:0] pb;
    logic          a_gt_b;
    logic [DW-1:0] sel_val;
    logic [IW-1:0] sel_idx;

    // in_ready_q is kept equal to (state_q == LOAD), so acceptance never
    // depends combinationally on in_valid beyond the final AND.
    assign accept    = in_valid && in_ready_q;
    assign load_last = accept && (cnt_q == IW'(NS - 1));

    assign pa = PAIR_A[pair_q];
    assign pb = PAIR_B[pair_q];

    median5_pair_cmp u_cmp (
        .a_i      (slot_q[pa]),
        .b_i      (slot_q[pb]),
        .ia_i     (pa),
        .ib_i     (pb),
        .a_gt_b_o (a_gt_b)
    );

    // Next ranks: clear at frame start, bump the winner of the current pair.
    always_comb begin
        rank_d = rank_q;
        if (load_last) begin
            for (int i = 0; i < NS; i++) rank_d[i] = '0;
        end else if (state_q == CMP) begin
            if (a_gt_b) rank_d[pa] = rank_q[pa] + RW'(1);
            else        rank_d[pb] = rank_q[pb] + RW'(1);
        end
    end

    // Pick the slot holding the median rank; exactly one matches once ranked.
    always_comb begin
        sel_val = '0;
        sel_idx = '0;
        for (int i = 0; i < NS; i++) begin
            if (rank_q[i] == MEDIAN_RANK) begin
                sel_val = slot_q[i];
                sel_idx = IW'(i);
            end
        end
    end

    // Sample storage: written only on an accepted transfer, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) slot_q[cnt_q] <= in_data;
    end

    // Rank counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NS; i++) rank_q[i] <= '0;
        end else begin
            rank_q <= rank_d;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            pair_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        cnt_q <= cnt_q + IW'(1);
                        if (load_last) begin
                            state_q    <= CMP;
                            pair_q     <= '0;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                CMP: begin
                    pair_q <= pair_q + PW'(1);
                    if (pair_q == PW'(NP - 1)) state_q <= SEL;
                end
                SEL: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= sel_val;
                    out_idx_q   <= sel_idx;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                default: begin
                    state_q    <= LOAD;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_median5_stream.sv
// Bench for median5_stream: directed frame table, a mid-compare reset case
// and randomized frames checked against a sort-based reference model.
module tb_median5_stream;
    import median_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;

    always #5 clk = ~clk;

    median5_stream dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    // Edges after the accepting edge until out_valid is visible:
    // out_valid is then high during the 12th cycle after acceptance.
    localparam int EXP_LAT = 11;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0][7:0] s;
        logic [7:0]      ed;
        logic [2:0]      ei;
        int              gap;
        int              hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int e, input int ed, input int ei,
                                input int gap, input int hold);
        vec_t v;
        v.s[0] = a[7:0]; v.s[1] = b[7:0]; v.s[2] = c[7:0];
        v.s[3] = d[7:0]; v.s[4] = e[7:0];
        v.ed   = ed[7:0];
        v.ei   = ei[2:0];
        v.gap  = gap;
        v.hold = hold;
        return v;
    endfunction

    // Reference: sort (value, arrival index) pairs, take the middle one.
    function automatic void model(input logic [4:0][7:0] v, output logic [7:0] md,
                                  output logic [2:0] mi);
        int sv[5];
        int si[5];
        int t;
        for (int i = 0; i < 5; i++) begin
            sv[i] = $signed(v[i]);
            si[i] = i;
        end
        for (int a = 0; a < 5; a++) begin
            for (int b = 0; b < 4; b++) begin
                if (sv[b] > sv[b+1] || (sv[b] == sv[b+1] && si[b] > si[b+1])) begin
                    t = sv[b]; sv[b] = sv[b+1]; sv[b+1] = t;
                    t = si[b]; si[b] = si[b+1]; si[b+1] = t;
                end
            end
        end
        md = sv[2][7:0];
        mi = si[2][2:0];
    endfunction

    task automatic send_sample(input logic [7:0] x, input string tag);
        int n = 0;
        in_valid = 1'b1;
        in_data  = x;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check({tag, " in_ready timeout"}, 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [4:0][7:0] s, input int gap, input string tag);
        for (int k = 0; k < 5; k++) begin
            send_sample(s[k], tag);
            if (k < 4) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int cyc = 0;
        out_ready = (v.hold == 0);
        send_frame(v.s, v.gap, tag);
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, EXP_LAT);
        check({tag, " out_data"}, out_data, v.ed);
        check({tag, " out_idx"}, out_idx, v.ei);
        for (int h = 0; h < v.hold; h++) begin
            if (h == 1) begin
                in_valid = 1'b1;
                in_data  = 8'hAA;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check({tag, " hold out_valid"}, out_valid, 1);
            check({tag, " hold out_data"}, out_data, v.ed);
            check({tag, " hold out_idx"}, out_idx, v.ei);
            check({tag, " hold in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " done out_valid"}, out_valid, 0);
        check({tag, " done in_ready"}, in_ready, 1);
        out_ready = 1'b0;
    endtask

    vec_t tbl[6];

    initial begin
        vec_t rv;
        logic [7:0] md;
        logic [2:0] mi;
        int cyc;

        tbl[0] = mk(10, 50, 30, 20, 40, 30, 2, 0, 0);
        tbl[1] = mk(8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h00, 2, 0, 0);
        tbl[2] = mk(5, 5, 5, 5, 5, 5, 2, 0, 0);
        tbl[3] = mk(7, 3, 7, 3, 7, 7, 0, 0, 0);
        tbl[4] = mk(1, 2, 3, 4, 5, 3, 2, 0, 20);
        tbl[5] = mk(100, -100, 0, -1, 1, 0, 2, 3, 0);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_idx", out_idx, 0);
        reset = 1'b0;

        for (int t = 0; t < 6; t++) run_frame(tbl[t], $sformatf("vec%0d", t));

        // Reset during the 5th compare cycle discards the frame.
        out_ready = 1'b1;
        rv = mk(1, 2, 3, 4, 5, 0, 0, 0, 0);
        send_frame(rv.s, 0, "rst");
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset out_valid", out_valid, 0);
        check("midreset in_ready", in_ready, 1);
        cyc = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) cyc++;
        end
        check("midreset stale output", cyc, 0);
        run_frame(mk(9, 8, 7, 6, 5, 7, 2, 0, 0), "postreset");

        // Randomized frames, some drawn from a tiny range to force ties.
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < 5; k++)
                rv.s[k] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3))
                                                      : 8'($urandom_range(0, 255));
            model(rv.s, md, mi);
            rv.ed   = md;
            rv.ei   = mi;
            rv.gap  = $urandom_range(0, 2);
            rv.hold = $urandom_range(0, 3);
            run_frame(rv, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
